// File: rtl/uart_tx_fifo.sv
// UART transmitter with an Avalon-MM slave port and a transmit FIFO.
// Register 0 pushes characters and reports status; register 1 holds divisor, parity and stop-bit settings.
module uart_tx_fifo #(
    parameter int              AAW = 1,
    parameter int              ADW = 32,
    parameter int              ABW = ADW / 8,
    parameter int              FAW = 4,
    parameter int              BDW = 16,
    parameter logic [BDW-1:0]  BDR = 16'd433
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           avalon_read,
    input  logic           avalon_write,
    input  logic [AAW-1:0] avalon_address,
    input  logic [ABW-1:0] avalon_byteenable,
    input  logic [ADW-1:0] avalon_writedata,
    output logic [ADW-1:0] avalon_readdata,
    output logic           avalon_waitrequest,
    output logic           uart_tx
);

    localparam int CW    = BDW + 3;
    localparam int CNTW  = FAW + 1;
    localparam int DEPTH = 2 ** FAW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    logic [CW-1:0]   ctrl;
    logic [CW-1:0]   wmask;
    logic [7:0]      mem [DEPTH];
    logic [FAW-1:0]  wr_ptr;
    logic [FAW-1:0]  rd_ptr;
    logic [CNTW-1:0] count;
    logic            full;
    logic            empty;
    logic            busy;
    logic [2:0]      state;
    logic [BDW-1:0]  baud_cnt;
    logic [BDW-1:0]  div_lat;
    logic            pen_lat;
    logic            podd_lat;
    logic            stop2_lat;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            tx_q;
    logic            data_sel;
    logic            ctrl_sel;
    logic            push;
    logic            pop;
    logic            bit_end;
    logic            frame_last;
    logic            unused_ok;

    assign data_sel   = (avalon_address == AAW'(0));
    assign ctrl_sel   = (avalon_address == AAW'(1));
    assign full       = count[FAW];
    assign empty      = (count == '0);
    assign busy       = (state != S_IDLE) || !empty;
    assign bit_end    = (baud_cnt == '0);
    assign frame_last = (state == S_STOP2) || (state == S_STOP1 && !stop2_lat);

    // A pop on the final stop-bit clock chains the next frame with no idle gap.
    assign pop  = !empty && ((state == S_IDLE) || (frame_last && bit_end));
    assign avalon_waitrequest = avalon_write && data_sel && full && !pop;
    assign push = avalon_write && data_sel && avalon_byteenable[0] && !avalon_waitrequest;

    assign uart_tx   = tx_q;
    assign unused_ok = ^{avalon_read, avalon_byteenable, avalon_writedata};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < CW; i++) wmask[i] = avalon_byteenable[i / 8];
    end

    always_comb begin
        avalon_readdata = '0;
        if (data_sel) begin
            avalon_readdata[FAW:0] = count;
            avalon_readdata[30]    = busy;
            avalon_readdata[31]    = full;
        end else begin
            avalon_readdata[CW-1:0] = ctrl;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= {3'b000, BDR};
        end else if (avalon_write && ctrl_sel) begin
            ctrl <= (ctrl & ~wmask) | (avalon_writedata[CW-1:0] & wmask);
        end
    end

    // NOTE: the storage array has no reset; pointer and count reset are what empty the FIFO.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= avalon_writedata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FAW'(1);
            if (pop)  rd_ptr <= rd_ptr + FAW'(1);
            if (push && !pop)      count <= count + CNTW'(1);
            else if (pop && !push) count <= count - CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            baud_cnt  <= BDR;
            div_lat   <= BDR;
            pen_lat   <= 1'b0;
            podd_lat  <= 1'b0;
            stop2_lat <= 1'b0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
        end else begin
            // The line follows the state one clock later, so a start bit appears two clocks after the push.
            case (state)
                S_START:  tx_q <= 1'b0;
                S_DATA:   tx_q <= shift_reg[bit_idx];
                S_PARITY: tx_q <= (^shift_reg) ^ podd_lat;
                default:  tx_q <= 1'b1;
            endcase

            if (pop) begin
                state     <= S_START;
                shift_reg <= mem[rd_ptr];
                baud_cnt  <= ctrl[BDW-1:0];
                div_lat   <= ctrl[BDW-1:0];
                pen_lat   <= ctrl[BDW];
                podd_lat  <= ctrl[BDW+1];
                stop2_lat <= ctrl[BDW+2];
                bit_idx   <= '0;
            end else if (state != S_IDLE) begin
                if (!bit_end) begin
                    baud_cnt <= baud_cnt - BDW'(1);
                end else begin
                    baud_cnt <= div_lat;
                    case (state)
                        S_START:  state <= S_DATA;
                        S_DATA: begin
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state <= pen_lat ? S_PARITY : S_STOP1;
                        end
                        S_PARITY: state <= S_STOP1;
                        S_STOP1:  state <= stop2_lat ? S_STOP2 : S_IDLE;
                        default:  state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
